// File: rtl/if_ctrl_pkg.sv
// if_ctrl_pkg: shared types and constants for the instruction-fetch controller.
// Holds the 2-bit FSM encoding, the default XLEN and the ack-wait timer width.
package if_ctrl_pkg;

  typedef enum logic [1:0] {
    IFC_IDLE  = 2'd0,
    IFC_REQ   = 2'd1,
    IFC_HOLD  = 2'd2,
    IFC_DRAIN = 2'd3
  } ifc_state_e;

  localparam int unsigned IFC_XLEN   = 32;
  localparam int unsigned IFC_TMR_W  = 8;
  localparam int unsigned IFC_PERF_W = 32;

  // Saturating increment so the wait timer never wraps back below the limit.
  function automatic logic [IFC_TMR_W-1:0] tmr_inc(input logic [IFC_TMR_W-1:0] t);
    logic [IFC_TMR_W-1:0] r;
    if (t == {IFC_TMR_W{1'b1}}) begin
      r = t;
    end else begin
      r = t + {{(IFC_TMR_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/ifc_perf_cnt.sv
// ifc_perf_cnt: three wrapping event counters (accepted fetches, HOLD cycles, redirects).
// The module only exists when IFC_PERF_CNT_EN is defined.
`ifdef IFC_PERF_CNT_EN
module ifc_perf_cnt
  import if_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_fetch,
  input  logic                  inc_stall,
  input  logic                  inc_flush,
  output logic [IFC_PERF_W-1:0] perf_fetch,
  output logic [IFC_PERF_W-1:0] perf_stall,
  output logic [IFC_PERF_W-1:0] perf_flush
);

  localparam logic [IFC_PERF_W-1:0] ONE = {{(IFC_PERF_W-1){1'b0}}, 1'b1};

  logic [IFC_PERF_W-1:0] fetch_q, fetch_d;
  logic [IFC_PERF_W-1:0] stall_q, stall_d;
  logic [IFC_PERF_W-1:0] flush_q, flush_d;

  // Next counter values; natural 2^32 wrap.
  always_comb begin
    fetch_d = fetch_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (inc_fetch) begin
      fetch_d = fetch_q + ONE;
    end else begin
      fetch_d = fetch_q;
    end
    if (inc_stall) begin
      stall_d = stall_q + ONE;
    end else begin
      stall_d = stall_q;
    end
    if (inc_flush) begin
      flush_d = flush_q + ONE;
    end else begin
      flush_d = flush_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= {IFC_PERF_W{1'b0}};
      stall_q <= {IFC_PERF_W{1'b0}};
      flush_q <= {IFC_PERF_W{1'b0}};
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perf_fetch = fetch_q;
  assign perf_stall = stall_q;
  assign perf_flush = flush_q;

endmodule
`endif

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage sequencer -- PC update control, imem req/ack, one-entry output register.
// Define IFC_PERF_CNT_EN to add the perf_fetch/perf_stall/perf_flush counter outputs.
module if_fetch_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = IFC_XLEN,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            id_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            pc_we,
  output logic            pc_Sel,
  output logic [XLEN-1:0] pc_branch,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            err_timeout
`ifdef IFC_PERF_CNT_EN
  ,
  output logic [IFC_PERF_W-1:0] perf_fetch,
  output logic [IFC_PERF_W-1:0] perf_stall,
  output logic [IFC_PERF_W-1:0] perf_flush
`endif
);

  localparam logic [XLEN-1:0]      INSN_BYTES = XLEN'(4);
  localparam logic [IFC_TMR_W-1:0] TMO_LAST   = IFC_TMR_W'(ACK_TIMEOUT - 1);

  ifc_state_e            state_q, state_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       tgt_q, tgt_d;
  logic [XLEN-1:0]       inst_q, inst_d;
  logic [XLEN-1:0]       inst_pc_q, inst_pc_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [IFC_TMR_W-1:0]  timer_q, timer_d;
  logic                  err_q, err_d;

  assign imem_req = (state_q == IFC_REQ) || (state_q == IFC_DRAIN);

  // FSM next state, PC-update control and output-register refill/consume.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tgt_d        = tgt_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q & id_stall;
    pc_we        = 1'b0;
    pc_Sel       = 1'b0;
    pc_branch    = tgt_q;
    if (br_taken) begin
      tgt_d        = br_target;
      pc_branch    = br_target;
      inst_valid_d = 1'b0;
    end else begin
      tgt_d = tgt_q;
    end
    case (state_q)
      IFC_IDLE: begin
        state_d = IFC_REQ;
        if (br_taken) begin
          pc_we  = 1'b1;
          pc_Sel = 1'b1;
          addr_d = br_target;
        end else begin
          addr_d = pc;
        end
      end
      IFC_REQ: begin
        if (br_taken) begin
          if (imem_ack) begin
            pc_we   = 1'b1;
            pc_Sel  = 1'b1;
            addr_d  = br_target;
            state_d = IFC_REQ;
          end else begin
            state_d = IFC_DRAIN;
          end
        end else if (imem_ack) begin
          if (!inst_valid_q || !id_stall) begin
            inst_d       = imem_rdata;
            inst_pc_d    = addr_q;
            inst_valid_d = 1'b1;
            pc_we        = 1'b1;
            if (id_stall) begin
              state_d = IFC_HOLD;
            end else begin
              state_d = IFC_REQ;
              addr_d  = pc + INSN_BYTES;
            end
          end else begin
            // Register full and stalled: drop the data without advancing PC, HOLD re-fetches it.
            state_d = IFC_HOLD;
          end
        end else begin
          state_d = IFC_REQ;
        end
      end
      IFC_HOLD: begin
        if (br_taken) begin
          pc_we   = 1'b1;
          pc_Sel  = 1'b1;
          addr_d  = br_target;
          state_d = IFC_REQ;
        end else if (!id_stall) begin
          addr_d  = pc;
          state_d = IFC_REQ;
        end else begin
          state_d = IFC_HOLD;
        end
      end
      IFC_DRAIN: begin
        if (imem_ack) begin
          pc_we   = 1'b1;
          pc_Sel  = 1'b1;
          addr_d  = br_taken ? br_target : tgt_q;
          state_d = IFC_REQ;
        end else begin
          state_d = IFC_DRAIN;
        end
      end
      default: begin
        state_d = IFC_IDLE;
      end
    endcase
  end

  // Ack-wait timer and sticky timeout flag; the request is never aborted.
  always_comb begin
    timer_d = timer_q;
    err_d   = err_q;
    if (imem_ack) begin
      timer_d = {IFC_TMR_W{1'b0}};
    end else if (imem_req) begin
      timer_d = tmr_inc(timer_q);
      if (timer_q == TMO_LAST) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      timer_d = timer_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IFC_IDLE;
      addr_q       <= {XLEN{1'b0}};
      tgt_q        <= {XLEN{1'b0}};
      inst_q       <= {XLEN{1'b0}};
      inst_pc_q    <= {XLEN{1'b0}};
      inst_valid_q <= 1'b0;
      timer_q      <= {IFC_TMR_W{1'b0}};
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tgt_q        <= tgt_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
    end
  end

  assign imem_addr   = addr_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign err_timeout = err_q;

`ifdef IFC_PERF_CNT_EN
  // A PC load without branch select only happens on an accepted fetch.
  ifc_perf_cnt u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_fetch  (pc_we && !pc_Sel),
    .inc_stall  (state_q == IFC_HOLD),
    .inc_flush  (br_taken),
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
  );
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed bench for if_fetch_ctrl with a flag-based behavioural model,
// a bench-side PC register and a fixed-latency instruction memory.
module tb_if_fetch_ctrl;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, br_target, imem_addr, imem_rdata, pc_branch, inst, inst_pc;
  logic        br_taken, id_stall, imem_req, imem_ack, pc_we, pc_Sel, inst_valid, err_timeout;

  int checks = 0;
  int failures = 0;

  // environment: memory and PC register
  int          mem_cnt, mem_lat;
  bit          mem_hold;
  logic [31:0] tb_pc;
  logic [31:0] ack_addrs[$];
  int          we_cnt;

  // sampled DUT outputs of the current tick
  logic        s_req, s_we, s_sel, s_valid, s_err, s_ack;
  logic [31:0] s_addr, s_branch, s_inst, s_ipc;

  // model state, next state and expected outputs
  bit          m_started, m_fetching, m_draining, m_holding, m_ov, m_err;
  logic [31:0] m_addr, m_tgt, m_inst, m_ipc;
  int          m_wait;
  bit          n_started, n_fetching, n_draining, n_holding, n_ov, n_err;
  logic [31:0] n_addr, n_tgt, n_inst, n_ipc;
  int          n_wait;
  bit          e_we, e_sel;
  logic [31:0] e_branch;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_stall    (id_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_we       (pc_we),
    .pc_Sel      (pc_Sel),
    .pc_branch   (pc_branch),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .err_timeout (err_timeout)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit will_ack();
    return imem_req && !mem_hold && (mem_cnt >= mem_lat);
  endfunction

  task automatic model_reset();
    m_started = 0; m_fetching = 0; m_draining = 0; m_holding = 0; m_ov = 0; m_err = 0;
    m_addr = 32'h0; m_tgt = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_wait = 0;
  endtask

  // What the fetch stage must do this cycle, from the behavioural rules.
  task automatic model_eval(input bit br, input logic [31:0] tgt, input bit stall,
                            input bit ack, input logic [31:0] rdata, input logic [31:0] cur_pc);
    n_started = m_started; n_fetching = m_fetching; n_draining = m_draining;
    n_holding = m_holding; n_err = m_err; n_addr = m_addr; n_tgt = m_tgt;
    n_inst = m_inst; n_ipc = m_ipc; n_wait = m_wait;
    n_ov = m_ov && stall;
    e_we = 0; e_sel = 0; e_branch = 32'h0;
    if (br) n_tgt = tgt;
    if (!m_started) begin
      n_started = 1; n_fetching = 1;
      if (br) begin e_we = 1; e_sel = 1; e_branch = tgt; n_addr = tgt; n_ov = 0; end
      else n_addr = cur_pc;
    end else if (br) begin
      n_ov = 0;
      if (m_fetching && !ack) n_draining = 1;
      else begin
        e_we = 1; e_sel = 1; e_branch = tgt; n_addr = tgt;
        n_fetching = 1; n_draining = 0; n_holding = 0;
      end
    end else if (m_fetching && ack) begin
      if (m_draining) begin
        e_we = 1; e_sel = 1; e_branch = m_tgt; n_addr = m_tgt; n_draining = 0;
      end else if (m_ov && stall) begin
        n_fetching = 0; n_holding = 1;
      end else begin
        n_inst = rdata; n_ipc = m_addr; n_ov = 1; e_we = 1;
        if (stall) begin n_fetching = 0; n_holding = 1; end
        else n_addr = cur_pc + 32'd4;
      end
    end else if (m_holding && !stall) begin
      n_holding = 0; n_fetching = 1; n_addr = cur_pc;
    end
    if (m_fetching && !ack) begin
      n_wait = m_wait + 1;
      if (n_wait >= 255) n_err = 1;
    end else if (ack) begin
      n_wait = 0;
    end
  endtask

  task automatic model_commit();
    m_started = n_started; m_fetching = n_fetching; m_draining = n_draining;
    m_holding = n_holding; m_ov = n_ov; m_err = n_err; m_addr = n_addr;
    m_tgt = n_tgt; m_inst = n_inst; m_ipc = n_ipc; m_wait = n_wait;
  endtask

  // One clock cycle: drive at negedge, compare at negedge+1, advance environment at next negedge.
  task automatic tick(input logic br, input logic [31:0] tgt, input logic stall);
    bit ack;
    ack = will_ack();
    br_taken = br; br_target = tgt; id_stall = stall;
    imem_ack = ack;
    imem_rdata = ack ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_we = pc_we; s_sel = pc_Sel; s_branch = pc_branch;
    s_valid = inst_valid; s_inst = inst; s_ipc = inst_pc; s_err = err_timeout; s_ack = ack;
    chk1("req", s_req, m_fetching);
    if (m_fetching) chk32("addr", s_addr, m_addr);
    chk1("inst_valid", s_valid, m_ov);
    if (m_ov) begin
      chk32("inst", s_inst, m_inst);
      chk32("inst_pc", s_ipc, m_ipc);
    end
    chk1("err", s_err, m_err);
    model_eval(br, tgt, stall, ack, imem_rdata, pc);
    chk1("pc_we", s_we, e_we);
    chk1("pc_sel", s_sel, e_sel);
    if (e_sel) chk32("pc_branch", s_branch, e_branch);
    if (ack) ack_addrs.push_back(s_addr);
    if (s_we) we_cnt++;
    @(posedge clk);
    @(negedge clk);
    model_commit();
    if (ack) mem_cnt = 0;
    else if (s_req) mem_cnt++;
    if (s_we) tb_pc = s_sel ? s_branch : tb_pc + 32'd4;
    pc = tb_pc;
    br_taken = 1'b0; imem_ack = 1'b0; id_stall = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!will_ack() && n < 16) begin
      tick(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk1({tag, "_ack_ready"}, will_ack(), 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk32({tag, "_addr"}, imem_addr, 32'h0);
    chk1({tag, "_pc_we"}, pc_we, 1'b0);
    chk1({tag, "_pc_sel"}, pc_Sel, 1'b0);
    chk32({tag, "_pc_branch"}, pc_branch, 32'h0);
    chk1({tag, "_valid"}, inst_valid, 1'b0);
    chk32({tag, "_inst"}, inst, 32'h0);
    chk32({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk1({tag, "_err"}, err_timeout, 1'b0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0; pc = 32'h0; br_taken = 1'b0; br_target = 32'h0; id_stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tb_pc = 32'h0; mem_cnt = 0; mem_lat = 2; mem_hold = 0; we_cnt = 0;
    model_reset();
    #2;
    check_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sequential fetch, ack two cycles after each request
    repeat (10) tick(1'b0, 32'h0, 1'b0);
    chk32("t1_nacks", 32'(ack_addrs.size()), 32'd3);
    if (ack_addrs.size() >= 3) begin
      chk32("t1_addr0", ack_addrs[0], 32'h0);
      chk32("t1_addr1", ack_addrs[1], 32'h4);
      chk32("t1_addr2", ack_addrs[2], 32'h8);
    end
    chk32("t1_we_cnt", 32'(we_cnt), 32'd3);
    chk32("t1_pc", tb_pc, 32'hC);
    chk1("t1_valid", inst_valid, 1'b1);
    chk32("t1_inst", inst, 32'h1357_9BD7);
    chk32("t1_inst_pc", inst_pc, 32'h8);

    // 2: ID back-pressure parks the controller in HOLD
    wait_ack("t2");
    tick(1'b0, 32'h0, 1'b1);
    chk1("t2_valid", inst_valid, 1'b1);
    chk32("t2_inst_pc", inst_pc, 32'hC);
    chk32("t2_inst", inst, 32'h1357_9BD3);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'h0, 1'b1);
      chk1("t2_hold_noreq", s_req, 1'b0);
      chk1("t2_hold_valid", s_valid, 1'b1);
      chk32("t2_hold_inst_pc", s_ipc, 32'hC);
    end
    tick(1'b0, 32'h0, 1'b0);
    chk1("t2_resume_req", imem_req, 1'b1);
    chk32("t2_resume_addr", imem_addr, 32'h10);
    chk1("t2_consumed", inst_valid, 1'b0);

    // 3: redirect in HOLD while ID still stalls
    wait_ack("t3");
    tick(1'b0, 32'h0, 1'b1);
    chk1("t3_held_valid", inst_valid, 1'b1);
    tick(1'b1, 32'h100, 1'b1);
    chk1("t3_pc_we", s_we, 1'b1);
    chk1("t3_pc_sel", s_sel, 1'b1);
    chk32("t3_pc_branch", s_branch, 32'h100);
    chk1("t3_valid_cleared", inst_valid, 1'b0);
    chk1("t3_req", imem_req, 1'b1);
    chk32("t3_addr", imem_addr, 32'h100);
    chk32("t3_pc", tb_pc, 32'h100);

    // 4: two redirects while a fetch is outstanding; the later target wins
    chk1("t4_no_ack_yet", will_ack(), 1'b0);
    tick(1'b1, 32'h200, 1'b0);
    chk1("t4_no_pc_we", s_we, 1'b0);
    chk1("t4_no_ack_yet2", will_ack(), 1'b0);
    tick(1'b1, 32'h300, 1'b0);
    wait_ack("t4");
    tick(1'b0, 32'h0, 1'b0);
    chk1("t4_ack", s_ack, 1'b1);
    chk1("t4_pc_we", s_we, 1'b1);
    chk1("t4_pc_sel", s_sel, 1'b1);
    chk32("t4_pc_branch", s_branch, 32'h300);
    chk1("t4_dropped", inst_valid, 1'b0);
    chk32("t4_addr", imem_addr, 32'h300);
    chk32("t4_pc", tb_pc, 32'h300);

    // 5: redirect, stall and ack all in one cycle
    wait_ack("t5");
    tick(1'b1, 32'h400, 1'b1);
    chk1("t5_pc_we", s_we, 1'b1);
    chk1("t5_pc_sel", s_sel, 1'b1);
    chk32("t5_pc_branch", s_branch, 32'h400);
    chk1("t5_valid", inst_valid, 1'b0);
    chk32("t5_addr", imem_addr, 32'h400);
    chk1("t5_req", imem_req, 1'b1);

    // 6: ack withheld past the timeout, then reset in the middle of a request
    mem_hold = 1;
    repeat (250) tick(1'b0, 32'h0, 1'b0);
    chk1("t6_err_before", err_timeout, 1'b0);
    chk1("t6_req_held", imem_req, 1'b1);
    repeat (10) tick(1'b0, 32'h0, 1'b0);
    chk1("t6_err_set", err_timeout, 1'b1);
    chk1("t6_req_still", imem_req, 1'b1);
    mem_hold = 0;
    wait_ack("t6");
    tick(1'b0, 32'h0, 1'b0);
    chk1("t6_late_ack", s_ack, 1'b1);
    chk1("t6_err_sticky", err_timeout, 1'b1);
    chk32("t6_late_inst_pc", inst_pc, 32'h400);
    chk1("t6_req_mid", imem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    model_reset();
    mem_cnt = 0; tb_pc = 32'h0; pc = 32'h0; we_cnt = 0;
    ack_addrs.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick(1'b0, 32'h0, 1'b0);
    chk32("t6_restart_nacks", 32'(ack_addrs.size()), 32'd1);
    if (ack_addrs.size() >= 1) chk32("t6_restart_addr", ack_addrs[0], 32'h0);
    chk1("t6_restart_err", err_timeout, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
